seq_alu: RTL and testbench

- Multi-cycle execution unit that consumes the 5-bit ALU operation code produced by the ALU control decoder and computes the result.
- Single-cycle operations are registered and return in 1 cycle.
- Shifts run iteratively, one bit per cycle, so the design needs no barrel shifter.
- Sits in the execute stage between the decoder/operand mux and writeback/branch logic, with valid/ready handshakes on both sides.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/seq_shifter.sv | 46 ++++
 rtl/seq_alu.sv | 96 +++++++++
 tb/tb_seq_alu.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, FSM states and constants shared by the decoder and seq_alu.
package alu_pkg;
    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_AND   = 5'b00011;
    localparam logic [4:0] ALU_OR    = 5'b00100;
    localparam logic [4:0] ALU_XOR   = 5'b00101;
    localparam logic [4:0] ALU_SLT   = 5'b00110;
    localparam logic [4:0] ALU_BEQ   = 5'b00111;
    localparam logic [4:0] ALU_SLL   = 5'b01000;
    localparam logic [4:0] ALU_SLTU  = 5'b01001;
    localparam logic [4:0] ALU_SRL   = 5'b01010;
    localparam logic [4:0] ALU_SRA   = 5'b01011;
    localparam logic [4:0] ALU_LUI   = 5'b01100;
    localparam logic [4:0] ALU_AUIPC = 5'b01101;
    localparam logic [4:0] ALU_BNE   = 5'b01110;
    localparam logic [4:0] ALU_BGE   = 5'b01111;
    localparam logic [4:0] ALU_BGEU  = 5'b10000;
    localparam logic [4:0] ALU_JALR  = 5'b10001;
    localparam logic [4:0] ALU_JAL   = 5'b10010;
    localparam int PC_INC = 4;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_L, SH_RL, SH_RA} shdir_t;
endpackage

// File: rtl/seq_shifter.sv
// seq_shifter: one-bit-per-cycle shifter; the first step is taken on start so an n-bit shift costs n cycles.
module seq_shifter
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [1:0]      dir,
    input  logic [XLEN-1:0] a,
    input  logic [SHW-1:0]  shamt,
    output logic [XLEN-1:0] first,
    output logic [XLEN-1:0] nxt,
    output logic            last
);
    logic [XLEN-1:0] work;
    logic [SHW-1:0]  cnt;
    logic [1:0]      kind;

    function automatic logic [XLEN-1:0] step(input logic [XLEN-1:0] v, input logic [1:0] k);
        return k == SH_L ? {v[XLEN-2:0], 1'b0} : {k == SH_RA && v[XLEN-1], v[XLEN-1:1]};
    endfunction

    assign first = step(a, dir);
    assign nxt   = step(work, kind);
    assign last  = cnt == SHW'(1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            work <= '0;
            cnt  <= '0;
            kind <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (start) begin
            work <= first;
            cnt  <= shamt - SHW'(1);
            kind <= dir;
        end else if (cnt != '0) begin
            work <= nxt;
            cnt  <= cnt - SHW'(1);
        end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle execute unit; single-cycle ops register in one cycle, shifts iterate in seq_shifter.
module seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken,
    output logic            illegal_op
);
    localparam int SHW = $clog2(XLEN);

    state_t          state;
    logic [XLEN-1:0] res, first, nxt;
    logic [SHW-1:0]  shamt;
    logic [1:0]      dir;
    logic            tk, ill, last, is_shift, start;

    assign shamt     = op_b[SHW-1:0];
    assign is_shift  = alu_control inside {ALU_SLL, ALU_SRL, ALU_SRA};
    assign dir       = alu_control == ALU_SLL ? SH_L : alu_control == ALU_SRL ? SH_RL : SH_RA;
    assign start     = state == IDLE && in_valid && !flush && is_shift && shamt > SHW'(1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    seq_shifter #(.XLEN(XLEN)) u_shifter (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .dir(dir),
        .a(op_a), .shamt(shamt), .first(first), .nxt(nxt), .last(last)
    );

    // Shifts of 0 or 1 bit finish here without visiting SHIFT.
    always_comb begin
        res = '0;
        tk  = 1'b0;
        ill = 1'b0;
        case (alu_control)
            ALU_ADD:   res = op_a + op_b;
            ALU_SUB:   res = op_a - op_b;
            ALU_AND:   res = op_a & op_b;
            ALU_OR:    res = op_a | op_b;
            ALU_XOR:   res = op_a ^ op_b;
            ALU_SLT:   begin tk = $signed(op_a) < $signed(op_b); res = {{XLEN-1{1'b0}}, tk}; end
            ALU_SLTU:  begin tk = op_a < op_b; res = {{XLEN-1{1'b0}}, tk}; end
            ALU_BEQ:   begin tk = op_a == op_b; res = op_a - op_b; end
            ALU_BNE:   begin tk = op_a != op_b; res = {{XLEN-1{1'b0}}, tk}; end
            ALU_BGE:   begin tk = $signed(op_a) >= $signed(op_b); res = {{XLEN-1{1'b0}}, tk}; end
            ALU_BGEU:  begin tk = op_a >= op_b; res = {{XLEN-1{1'b0}}, tk}; end
            ALU_SLL, ALU_SRL, ALU_SRA: res = shamt == '0 ? op_a : first;
            ALU_LUI:   res = op_b;
            ALU_AUIPC: res = pc + op_b;
            ALU_JALR, ALU_JAL: begin tk = 1'b1; res = pc + XLEN'(PC_INC); end
            default:   ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= IDLE;
            result       <= '0;
            branch_taken <= 1'b0;
            illegal_op   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (start) begin
                        state <= SHIFT;
                    end else begin
                        result       <= res;
                        branch_taken <= tk;
                        illegal_op   <= ill;
                        state        <= DONE;
                    end
                end
                SHIFT: if (last) begin
                    result       <= nxt;
                    branch_taken <= 1'b0;
                    illegal_op   <= 1'b0;
                    state        <= DONE;
                end
                default: if (out_ready) state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized scoreboard bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;
    import alu_pkg::*;

    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
    logic        in_ready, out_valid, branch_taken, illegal_op;
    logic [4:0]  alu_control = '0;
    logic [31:0] op_a = '0, op_b = '0, pc = '0, result;

    typedef struct {
        logic [31:0] res;
        logic        tk;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0, errors = 0, checks = 0;
    bit   seen = 0, hold = 0, rand_rdy = 0;
    logic [4:0] ops [18] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_BEQ, ALU_SLL, ALU_SLTU,
                             ALU_SRL, ALU_SRA, ALU_LUI, ALU_AUIPC, ALU_BNE, ALU_BGE, ALU_BGEU, ALU_JALR, ALU_JAL};

    seq_alu dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .op_a(op_a), .op_b(op_b), .pc(pc), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .branch_taken(branch_taken), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        out_ready = hold ? 1'b0 : rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] p);
        exp_t e;
        int s;
        s = int'(b[4:0]);
        e.res = '0; e.tk = 0; e.ill = 0; e.lat = 1; e.acc = 0;
        case (op)
            ALU_ADD:   e.res = a + b;
            ALU_SUB:   e.res = a - b;
            ALU_AND:   e.res = a & b;
            ALU_OR:    e.res = a | b;
            ALU_XOR:   e.res = a ^ b;
            ALU_SLT:   begin e.tk = $signed(a) < $signed(b); e.res = {31'b0, e.tk}; end
            ALU_SLTU:  begin e.tk = a < b; e.res = {31'b0, e.tk}; end
            ALU_BEQ:   begin e.tk = a == b; e.res = a - b; end
            ALU_BNE:   begin e.tk = a != b; e.res = {31'b0, e.tk}; end
            ALU_BGE:   begin e.tk = $signed(a) >= $signed(b); e.res = {31'b0, e.tk}; end
            ALU_BGEU:  begin e.tk = a >= b; e.res = {31'b0, e.tk}; end
            ALU_SLL:   begin e.res = a << s; e.lat = s > 1 ? s : 1; end
            ALU_SRL:   begin e.res = a >> s; e.lat = s > 1 ? s : 1; end
            ALU_SRA:   begin e.res = $signed(a) >>> s; e.lat = s > 1 ? s : 1; end
            ALU_LUI:   e.res = b;
            ALU_AUIPC: e.res = p + b;
            ALU_JALR, ALU_JAL: begin e.tk = 1; e.res = p + 32'd4; end
            default:   e.ill = 1;
        endcase
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
        exp_t e;
        wait_idle();
        if (!in_ready) return;
        alu_control = op; op_a = a; op_b = b; pc = p; in_valid = 1;
        e = model(op, a, b, p);
        e.acc = cyc;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 0; alu_control = 5'($urandom); op_a = $urandom; op_b = $urandom; pc = $urandom;
    endtask

    // Every cycle a result is presented it must match the head of the queue, which also covers hold stability.
    always @(negedge clk) if (rst_n && out_valid) begin
        if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_out_valid: got 1 expected 0 (result=%h)", result);
        end else begin
            chk("result", result, q[0].res);
            chk("branch_taken", 32'(branch_taken), 32'(q[0].tk));
            chk("illegal_op", 32'(illegal_op), 32'(q[0].ill));
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            if (!seen) begin
                seen = 1;
                chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
            end
            if (out_ready) begin
                void'(q.pop_front());
                seen = 0;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_taken", 32'(branch_taken), 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        @(negedge clk) rst_n = 1;

        issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
        issue(ALU_SRA, 32'h8000_0000, 32'd31, 32'd0);
        issue(ALU_SRA, 32'h8000_0000, 32'd0, 32'd0);
        issue(ALU_SLL, 32'h0000_0003, 32'd1, 32'd0);
        issue(ALU_SLT, 32'hFFFF_FFFE, 32'd1, 32'd0);
        issue(ALU_SLTU, 32'hFFFF_FFFE, 32'd1, 32'd0);
        @(negedge clk) hold = 1;
        issue(ALU_JAL, 32'd0, 32'd0, 32'h0000_1000);
        repeat (5) @(posedge clk);
        @(negedge clk) hold = 0;
        issue(5'b00010, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
        issue(ALU_ADD, 32'd2, 32'd3, 32'd0);

        // flush mid-shift: nothing may be emitted
        wait_idle();
        alu_control = ALU_SLL; op_a = 32'h0000_00FF; op_b = 32'd20; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        repeat (25) @(posedge clk);

        // flush together with in_valid in IDLE: request is dropped
        #1;
        alu_control = ALU_ADD; op_a = 32'd7; op_b = 32'd8; in_valid = 1; flush = 1;
        @(posedge clk); #1;
        in_valid = 0; flush = 0;
        chk("flush_accept_in_ready", 32'(in_ready), 32'd1);
        chk("flush_accept_out_valid", 32'(out_valid), 32'd0);
        repeat (3) @(posedge clk);

        // reset mid-shift: outputs return to reset values at once
        issue(ALU_JALR, 32'd0, 32'd0, 32'h0000_2000);
        wait_idle();
        alu_control = ALU_SLL; op_a = 32'h0000_0001; op_b = 32'd20; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_taken", 32'(branch_taken), 32'd0);
        chk("arst_illegal", 32'(illegal_op), 32'd0);
        @(negedge clk) rst_n = 1;
        repeat (25) @(posedge clk);

        rand_rdy = 1;
        for (int i = 0; i < 200; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            op = $urandom_range(0, 9) == 0 ? 5'($urandom) : ops[$urandom_range(0, 17)];
            a  = $urandom;
            b  = $urandom_range(0, 3) == 0 ? a : $urandom;
            issue(op, a, b, $urandom);
        end
        rand_rdy = 0;
        for (int n = 0; n < 2000 && q.size() != 0; n++) @(posedge clk);
        chk("drain_pending", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
